// File: rtl/instr_loader.sv
// Boot-time loader: takes a length-prefixed byte stream and writes little-endian 32-bit words
// into instruction memory, holding the CPU until the load finishes or the header is rejected.
module instr_loader #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned OUT_WIDTH     = 32,
  parameter int unsigned MEM_BYTES     = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [OUT_WIDTH-1:0]     wr_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StDone, StError
  } state_e;

  state_e state_q, state_d;

  logic [7:0]                  len_lo_q;
  logic [13:0]                 len_words_q;
  logic [15:0]                 word_idx_q;
  logic [1:0]                  byte_cnt_q;
  logic [3*DATA_WIDTH-1:0]     word_q;
  logic [ADDRESS_WIDTH-1:0]    wr_addr_q;
  logic [OUT_WIDTH-1:0]        wr_data_q;

  logic        accept;
  logic [15:0] len_hdr;
  logic        len_bad;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign len_hdr   = {in_data[7:0], len_lo_q};
  assign len_bad   = (len_hdr == 16'd0) || (len_hdr[1:0] != 2'b00) || (32'(len_hdr) > MEM_BYTES);
  assign last_word = (word_idx_q + 16'd1) == {2'b00, len_words_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLenLo;
      StLenLo: if (accept) state_d = StLenHi;
      StLenHi: if (accept) state_d = len_bad ? StError : StData;
      StData:  if (accept && byte_cnt_q == 2'd3) state_d = StWrite;
      StWrite: state_d = last_word ? StDone : StData;
      StDone:  if (start) state_d = StLenLo;
      StError: if (start) state_d = StLenLo;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      StLenLo, StLenHi, StData: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      StWrite: begin
        wr_en    = 1'b1;
        cpu_hold = 1'b1;
      end
      StDone:  done = 1'b1;
      StError: err  = 1'b1;
      default: ;
    endcase
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // Datapath: header capture, lane assembly; write address/data latch only on the 4th byte
  // so they hold steady between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_q    <= '0;
      len_words_q <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      unique case (state_q)
        StLenLo: if (accept) len_lo_q <= in_data[7:0];
        StLenHi: begin
          if (accept) begin
            len_words_q <= len_hdr[15:2];
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
          end
        end
        StData: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            unique case (byte_cnt_q)
              2'd0: word_q[0 +: DATA_WIDTH]            <= in_data;
              2'd1: word_q[DATA_WIDTH +: DATA_WIDTH]   <= in_data;
              2'd2: word_q[2*DATA_WIDTH +: DATA_WIDTH] <= in_data;
              default: begin
                wr_data_q <= {in_data, word_q};
                wr_addr_q <= ADDRESS_WIDTH'({word_idx_q, 2'b00});
              end
            endcase
          end
        end
        StWrite: word_idx_q <= word_idx_q + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
